// File: rtl/sine_sweep_ctrl_if.sv
// rtl/sine_sweep_ctrl_if.sv - control/config/status bundle between sweep master and sine_sweep_ctrl
interface sine_sweep_ctrl_if #(
   parameter int STEP_WIDTH  = 31,
   parameter int DWELL_WIDTH = 16,
   parameter int IDX_WIDTH   = 16
);
   logic                   start;
   logic                   abort;
   logic                   mode_cont;
   logic [STEP_WIDTH-1:0]  cfg_start_step;
   logic [STEP_WIDTH-1:0]  cfg_stop_step;
   logic [STEP_WIDTH-1:0]  cfg_inc_step;
   logic [DWELL_WIDTH-1:0] cfg_dwell;
   logic [STEP_WIDTH-1:0]  step;
   logic                   point_strobe;
   logic [IDX_WIDTH-1:0]   point_idx;
   logic                   busy;
   logic                   done;
   logic                   cfg_err;

   modport master (
      output start, abort, mode_cont, cfg_start_step, cfg_stop_step, cfg_inc_step, cfg_dwell,
      input  step, point_strobe, point_idx, busy, done, cfg_err
   );

   modport slave (
      input  start, abort, mode_cont, cfg_start_step, cfg_stop_step, cfg_inc_step, cfg_dwell,
      output step, point_strobe, point_idx, busy, done, cfg_err
   );
endinterface

// File: rtl/sine_sweep_ctrl.sv
// rtl/sine_sweep_ctrl.sv - stepped frequency sweep sequencer feeding sine_gen.step
module sine_sweep_ctrl #(
   parameter int STEP_WIDTH  = 31,
   parameter int DWELL_WIDTH = 16,
   parameter int IDX_WIDTH   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   sine_sweep_ctrl_if.slave  bus
);
   typedef enum logic {S_IDLE = 1'b0, S_DWELL = 1'b1} state_t;

   localparam logic [DWELL_WIDTH-1:0] DW_ONE  = 1;
   localparam logic [IDX_WIDTH-1:0]   IDX_ONE = 1;

   state_t                 state_q, state_d;
   logic [STEP_WIDTH-1:0]  step_q, step_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;
   logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
   logic                   strobe_q, strobe_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [STEP_WIDTH-1:0]  start_l, start_d;
   logic [STEP_WIDTH-1:0]  stop_l, stop_d;
   logic [STEP_WIDTH-1:0]  inc_l, inc_d;
   logic [DWELL_WIDTH-1:0] dwell_l, dwell_d;
   logic                   cont_l, cont_d;

   // Config sanity and next-point arithmetic; the extra sum bit catches wrap past the step range.
   logic                   cfg_ok;
   logic [STEP_WIDTH:0]    sum;
   logic                   past_end;
   logic                   accept;

   assign cfg_ok   = (bus.cfg_inc_step != '0) && (bus.cfg_dwell != '0) &&
                     (bus.cfg_start_step <= bus.cfg_stop_step);
   assign sum      = {1'b0, step_q} + {1'b0, inc_l};
   assign past_end = sum[STEP_WIDTH] || (sum[STEP_WIDTH-1:0] > stop_l);
   assign accept   = (state_q == S_IDLE) && bus.start && !bus.abort && cfg_ok;

   // State and datapath registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         step_q   <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         start_l  <= '0;
         stop_l   <= '0;
         inc_l    <= '0;
         dwell_l  <= '0;
         cont_l   <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
         err_q    <= err_d;
         start_l  <= start_d;
         stop_l   <= stop_d;
         inc_l    <= inc_d;
         dwell_l  <= dwell_d;
         cont_l   <= cont_d;
      end
   end

   // Next state: abort always returns to idle; a single sweep ends when the next point is out of range.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_DWELL;
         S_DWELL: begin
            if (bus.abort)
               state_d = S_IDLE;
            else if ((cnt_q == '0) && past_end && !cont_l)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values: step, index, dwell count and one-cycle pulses.
   always_comb begin
      step_d   = step_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      strobe_d = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      start_d  = start_l;
      stop_d   = stop_l;
      inc_d    = inc_l;
      dwell_d  = dwell_l;
      cont_d   = cont_l;
      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               if (cfg_ok) begin
                  start_d  = bus.cfg_start_step;
                  stop_d   = bus.cfg_stop_step;
                  inc_d    = bus.cfg_inc_step;
                  dwell_d  = bus.cfg_dwell;
                  cont_d   = bus.mode_cont;
                  step_d   = bus.cfg_start_step;
                  idx_d    = '0;
                  cnt_d    = bus.cfg_dwell - DW_ONE;
                  strobe_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_DWELL: begin
            if (bus.abort) begin
               step_d = '0;
               idx_d  = '0;
               cnt_d  = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DW_ONE;
            end else if (!past_end) begin
               step_d   = sum[STEP_WIDTH-1:0];
               idx_d    = idx_q + IDX_ONE;
               cnt_d    = dwell_l - DW_ONE;
               strobe_d = 1'b1;
            end else if (cont_l) begin
               step_d   = start_l;
               idx_d    = '0;
               cnt_d    = dwell_l - DW_ONE;
               strobe_d = 1'b1;
            end else begin
               step_d = '0;
               idx_d  = '0;
               cnt_d  = '0;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.step         = step_q;
   assign bus.point_idx    = idx_q;
   assign bus.point_strobe = strobe_q;
   assign bus.busy         = (state_q == S_DWELL);
   assign bus.done         = done_q;
   assign bus.cfg_err      = err_q;
endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// tb/tb_sine_sweep_ctrl.sv - scoreboard bench for sine_sweep_ctrl
module tb_sine_sweep_ctrl;
   typedef logic [50:0] exp_t;   // {step[30:0], strobe, idx[15:0], busy, done, cfg_err}

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   exp_t obs, exp_v;

   sine_sweep_ctrl_if bus ();

   sine_sweep_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [30:0] s, input logic strb, input logic [15:0] idx,
                               input logic bsy, input logic dn, input logic err);
      return {s, strb, idx, bsy, dn, err};
   endfunction

   function automatic exp_t sample();
      return {bus.step, bus.point_strobe, bus.point_idx, bus.busy, bus.done, bus.cfg_err};
   endfunction

   // Reference sweep: enumerate point values, each held dwell cycles; end with done or wrap.
   task automatic push_sweep(input longint s, input longint stop, input longint inc,
                             input int dwell, input bit cont, input int max_cycles);
      longint      v = s;
      logic [15:0] idx = 0;
      int          cyc = 0;
      while (cyc < max_cycles) begin
         if (v > stop) begin
            if (cont) begin
               v = s;
               idx = 0;
            end else begin
               q.push_back(mk(0, 0, 0, 0, 1, 0));
               break;
            end
         end
         for (int d = 0; d < dwell && cyc < max_cycles; d++) begin
            q.push_back(mk(31'(v), d == 0, idx, 1, 0, 0));
            cyc++;
         end
         v = v + inc;
         idx = idx + 16'd1;
      end
   endtask

   task automatic set_cfg(input logic [30:0] s, input logic [30:0] e, input logic [30:0] i,
                          input logic [15:0] d, input logic cont);
      bus.cfg_start_step = s;
      bus.cfg_stop_step  = e;
      bus.cfg_inc_step   = i;
      bus.cfg_dwell      = d;
      bus.mode_cont      = cont;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) rst_n = 1'b1;
         q.push_back(mk(0, 0, 0, 0, 0, 0));
         @(posedge clk); #1;
         exp_v = q.pop_front();
         obs = sample();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset c=%0d got=%h exp=%h", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_single();
      int c = 0;
      set_cfg(4, 10, 3, 2, 1'b0);
      bus.start = 1'b1;
      push_sweep(4, 10, 3, 2, 1'b0, 100);
      q.push_back(mk(0, 0, 0, 0, 0, 0));
      while (q.size() > 0) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         exp_v = q.pop_front();
         obs = sample();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL single c=%0d got=%h exp=%h", c, obs, exp_v);
         end
         c++;
      end
   endtask

   task automatic test_continuous();
      int c = 0;
      set_cfg(1, 3, 1, 1, 1'b1);
      bus.start = 1'b1;
      push_sweep(1, 3, 1, 1, 1'b1, 9);
      while (q.size() > 0) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.mode_cont = 1'b0;
         exp_v = q.pop_front();
         obs = sample();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL continuous c=%0d got=%h exp=%h", c, obs, exp_v);
         end
         c++;
      end
      bus.abort = 1'b1;
      q.push_back(mk(0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      bus.abort = 1'b0;
      exp_v = q.pop_front();
      obs = sample();
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL continuous_abort got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_bad_cfg();
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       set_cfg(4, 10, 0, 2, 1'b0);
            1:       set_cfg(9, 5, 1, 2, 1'b0);
            default: set_cfg(4, 10, 3, 0, 1'b0);
         endcase
         bus.start = 1'b1;
         q.push_back(mk(0, 0, 0, 0, 0, 1));
         q.push_back(mk(0, 0, 0, 0, 0, 0));
         while (q.size() > 0) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            exp_v = q.pop_front();
            obs = sample();
            checks++;
            if (obs !== exp_v) begin
               failures++;
               $display("FAIL bad_cfg k=%0d got=%h exp=%h", k, obs, exp_v);
            end
         end
      end
   endtask

   task automatic test_overflow();
      int c = 0;
      set_cfg(31'h7FFF_FFFE, 31'h7FFF_FFFF, 4, 2, 1'b0);
      bus.start = 1'b1;
      push_sweep(64'h7FFF_FFFE, 64'h7FFF_FFFF, 4, 2, 1'b0, 100);
      q.push_back(mk(0, 0, 0, 0, 0, 0));
      while (q.size() > 0) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         exp_v = q.pop_front();
         obs = sample();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL overflow c=%0d got=%h exp=%h", c, obs, exp_v);
         end
         c++;
      end
   endtask

   task automatic test_abort();
      int c = 0;
      set_cfg(4, 10, 3, 2, 1'b0);
      bus.start = 1'b1;
      push_sweep(4, 10, 3, 2, 1'b0, 100);
      while (q.size() > 0) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.abort = 1'b0;
         exp_v = q.pop_front();
         obs = sample();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL abort c=%0d got=%h exp=%h", c, obs, exp_v);
         end
         if (c == 1) begin
            set_cfg(100, 200, 5, 7, 1'b1);
            bus.start = 1'b1;
         end
         if (c == 4) begin
            bus.abort = 1'b1;
            q.delete();
            q.push_back(mk(0, 0, 0, 0, 0, 0));
            q.push_back(mk(0, 0, 0, 0, 0, 0));
         end
         c++;
      end
      set_cfg(4, 10, 3, 2, 1'b0);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      q.push_back(mk(0, 0, 0, 0, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0));
      while (q.size() > 0) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.abort = 1'b0;
         exp_v = q.pop_front();
         obs = sample();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL abort_with_start got=%h exp=%h", obs, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid();
      int c = 0;
      set_cfg(4, 10, 3, 2, 1'b0);
      bus.start = 1'b1;
      push_sweep(4, 10, 3, 2, 1'b0, 100);
      while (q.size() > 0) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         exp_v = q.pop_front();
         obs = sample();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs, exp_v);
         end
         if (c == 2) begin
            rst_n = 1'b0;
            q.delete();
            q.push_back(mk(0, 0, 0, 0, 0, 0));
         end
         if (c == 3) begin
            rst_n = 1'b1;
            q.push_back(mk(0, 0, 0, 0, 0, 0));
         end
         if (c == 4) begin
            bus.start = 1'b1;
            push_sweep(4, 10, 3, 2, 1'b0, 100);
            q.push_back(mk(0, 0, 0, 0, 0, 0));
         end
         c++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      set_cfg(0, 0, 0, 0, 1'b0);
      test_reset();
      test_single();
      test_continuous();
      test_bad_cfg();
      test_overflow();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sine_sweep_ctrl.md
Name: sine_sweep_ctrl

Overview:
- Sequencer that drives the phase-increment (step) input of sine_gen.
- Steps the carrier frequency from a start step to a stop step in fixed increments, holding each point for a programmable dwell.
- Supports single-shot and continuous (wrap-around) sweeps, with start/abort control and busy/done status.
- Sits between the control/config logic and sine_gen; its step output connects directly to sine_gen.step.

Parameters:
STEP_WIDTH, 31, width of phase-increment word (matches sine_gen step port)
DWELL_WIDTH, 16, width of dwell counter (clocks per sweep point)
IDX_WIDTH, 16, width of point index counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
start  in  1  single-cycle request to begin a sweep; sampled only in IDLE
abort  in  1  stop the sweep immediately; any state
mode_cont  in  1  1 = continuous (wrap to start), 0 = single sweep; latched at start
cfg_start_step  in  STEP_WIDTH  first step value; latched at start
cfg_stop_step  in  STEP_WIDTH  upper bound of step values; latched at start
cfg_inc_step  in  STEP_WIDTH  increment between points; latched at start
cfg_dwell  in  DWELL_WIDTH  clocks each point is held; latched at start
step  out  STEP_WIDTH  phase increment to sine_gen
point_strobe  out  1  one-cycle pulse on the first cycle of each new step value
point_idx  out  IDX_WIDTH  index of current point within sweep, 0-based
busy  out  1  high while sweeping
done  out  1  one-cycle pulse when a single sweep completes normally
cfg_err  out  1  one-cycle pulse when start is rejected for bad config

Behaviour:
- Synchronous active-low reset, sampled on the clk rising edge. Reset forces state IDLE and all outputs to 0: step, point_strobe, point_idx, busy, done, cfg_err.
- Reset mid-sweep behaves identically: everything is cleared on the next edge.
- States:
  - IDLE: waiting for start.
  - DWELL: holding the current point.
- IDLE, start=1, abort=0:
  - Config is rejected if cfg_inc_step==0, cfg_dwell==0, or cfg_start_step>cfg_stop_step.
  - Rejected: cfg_err=1 for one cycle, stay in IDLE, step unchanged at 0.
  - Accepted: latch all cfg_* and mode_cont. On the next cycle (latency 1): step=start, point_idx=0, point_strobe=1, busy=1, dwell counter=cfg_dwell-1, go to DWELL.
- DWELL:
  - Counter decrements each cycle.
  - When the counter is 0, compute next = step + inc in STEP_WIDTH+1 bits.
  - next <= stop (no carry): next cycle step=next, point_idx+1, point_strobe=1, counter reloads.
  - next > stop or carry out, continuous mode: next cycle step=start, point_idx=0, point_strobe=1, counter reloads. Never asserts done.
  - next > stop or carry out, single mode: next cycle go to IDLE with step=0, busy=0, point_idx=0, done=1 for one cycle.
- Timing: each step value is held exactly cfg_dwell cycles. There is no gap cycle between points.
- point_idx wraps modulo 2^IDX_WIDTH; this has no effect on sequencing.
- Abort (highest priority, any state): next cycle state=IDLE, step=0, busy=0, point_idx=0. No done pulse and no point_strobe are generated.
- Abort and start asserted together in IDLE: abort wins; start is ignored and cfg_err is not asserted.
- Start while busy is ignored. Config inputs may change freely during a sweep; the latched copies are used.
- done and cfg_err are never high in the same cycle. point_strobe is never high in IDLE.

Test Plan:
- Single sweep: start=4, stop=10, inc=3, dwell=2, pulse start at cycle N -> step=4 at N+1..N+2, 7 at N+3..N+4, 10 at N+5..N+6; point_strobe at N+1, N+3, N+5; N+7: step=0, busy=0, done=1 for one cycle.
- Continuous sweep: start=1, stop=3, inc=1, dwell=1, mode_cont=1 -> step sequence 1,2,3,1,2,3,..., point_strobe every cycle, point_idx 0,1,2,0,...; done never asserted.
- Bad config: inc=0 (and separately start=9 with stop=5, and dwell=0) -> cfg_err one-cycle pulse, busy stays 0, step stays 0.
- Overflow boundary: STEP_WIDTH=31, start=0x7FFFFFFE, stop=0x7FFFFFFF, inc=4 -> one point only (0x7FFFFFFE), then done; no wrap to a small step value.
- Abort mid-dwell at third point of the single-sweep case -> next cycle step=0, busy=0, no done pulse. A start during the sweep is ignored. Abort and start in the same IDLE cycle -> stays IDLE.
- Reset asserted (rst_n=0) mid-sweep for one cycle -> all outputs 0 on the next edge. After release, a new start works normally with latency 1.
